// File: rtl/tof_sample_latch.sv
// tof_sample_latch: holds the latest sample of each ToF channel, raises a data-ready flag per channel,
// releases it on a write-FSM consume and counts completed frames.
// Optional macro TOF_OVERFLOW_CNT_EN adds ovf_cnt, a saturating 8-bit overwrite counter per channel.
module tof_sample_latch #(
  parameter int N_CH = 8,
  parameter int DW = 16,
  parameter int FCW = 16,
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   sample_valid,
  input  logic [N_CH*DW-1:0] sample_data,
  output logic [N_CH-1:0]   ToF_dr,
  input  logic [IW-1:0]     ToF_Index,
  input  logic              rd_ack,
  output logic [DW-1:0]     rd_data,
  output logic              frame_done,
  output logic [FCW-1:0]    frame_cnt,
  output logic              ack_err
`ifdef TOF_OVERFLOW_CNT_EN
  ,
  output logic [N_CH*8-1:0] ovf_cnt
`endif
);
  localparam logic [IW:0] NCH_L = (IW+1)'(N_CH);
  logic [DW-1:0] hold_q [N_CH];
  logic [DW-1:0] hold_d [N_CH];
  logic [N_CH-1:0] dr_q, dr_d, consumed_q, consumed_d, hit;
  logic ack_q, consume, idx_ok, cons_ok, ack_err_q, ack_err_d, frame_done_q, frame_done_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  // Consume is the rising edge of rd_ack; a full consumed mask closes the frame and restarts the mask,
  // so a consume landing in the frame_done cycle already belongs to the next frame.
  always_comb begin
    consume = rd_ack & ~ack_q;
    idx_ok = {1'b0, ToF_Index} < NCH_L;
    cons_ok = consume & idx_ok & dr_q[ToF_Index];
    hit = cons_ok ? N_CH'(1) << ToF_Index : '0;
    for (int i = 0; i < N_CH; i++) hold_d[i] = sample_valid[i] ? sample_data[i*DW +: DW] : hold_q[i];
    dr_d = sample_valid | (dr_q & ~hit);
    consumed_d = ((&consumed_q) ? '0 : consumed_q) | hit;
    frame_done_d = &consumed_d;
    frame_cnt_d = frame_cnt_q + FCW'(&consumed_q);
    ack_err_d = ack_err_q | (consume & ~cons_ok);
    rd_data_d = idx_ok ? hold_q[ToF_Index] : '0;
  end

  // State registers; reset drops held samples and flags immediately.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
      dr_q <= '0;
      consumed_q <= '0;
      ack_q <= 1'b0;
      ack_err_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      hold_q <= hold_d;
      dr_q <= dr_d;
      consumed_q <= consumed_d;
      ack_q <= rd_ack;
      ack_err_q <= ack_err_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q <= rd_data_d;
    end

  assign ToF_dr = dr_q;
  assign rd_data = rd_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt = frame_cnt_q;
  assign ack_err = ack_err_q;

`ifdef TOF_OVERFLOW_CNT_EN
  logic [7:0] ovf_q [N_CH];
  logic [7:0] ovf_d [N_CH];

  // A sample landing on a full channel that is not being consumed loses the older value; count it, saturating.
  always_comb
    for (int i = 0; i < N_CH; i++)
      ovf_d[i] = ovf_q[i] + 8'(sample_valid[i] & dr_q[i] & ~hit[i] & ~(&ovf_q[i]));

  // Overwrite counters.
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < N_CH; i++) ovf_q[i] <= '0;
    else ovf_q <= ovf_d;

  // Pack the counters onto the output bus.
  always_comb
    for (int i = 0; i < N_CH; i++) ovf_cnt[i*8 +: 8] = ovf_q[i];
`endif
endmodule

// File: tb/tb_tof_sample_latch.sv
// tb_tof_sample_latch: directed and randomized checks of tof_sample_latch against a per-cycle behavioural model.
module tb_tof_sample_latch;
  logic clk = 1'b0, reset = 1'b1, rd_ack = 1'b0;
  logic [7:0] sample_valid = '0;
  logic [127:0] sample_data = '0;
  logic [7:0] ToF_dr;
  logic [2:0] ToF_Index = '0;
  logic [15:0] rd_data;
  logic frame_done, ack_err;
  logic [3:0] frame_cnt;
`ifdef TOF_OVERFLOW_CNT_EN
  logic [63:0] ovf_cnt;
  int m_ovf [8];
`endif
  int n_checks = 0, n_pass = 0;
  logic [15:0] m_hold [8];
  logic [7:0] m_dr = '0, m_cons = '0;
  logic m_ackq = 1'b0, m_err = 1'b0, m_fd = 1'b0;
  int m_fcnt = 0;
  logic [15:0] m_rd = '0;

  tof_sample_latch #(.N_CH(8), .DW(16), .FCW(4)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_data(sample_data),
    .ToF_dr(ToF_dr), .ToF_Index(ToF_Index), .rd_ack(rd_ack), .rd_data(rd_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .ack_err(ack_err)
`ifdef TOF_OVERFLOW_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hold[i] = '0;
    m_dr = '0; m_cons = '0; m_ackq = 1'b0; m_err = 1'b0; m_fd = 1'b0; m_fcnt = 0; m_rd = '0;
`ifdef TOF_OVERFLOW_CNT_EN
    for (int i = 0; i < 8; i++) m_ovf[i] = 0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".dr"}, 32'(ToF_dr), 32'(m_dr));
    chk({tag, ".rd"}, 32'(rd_data), 32'(m_rd));
    chk({tag, ".fd"}, 32'(frame_done), 32'(m_fd));
    chk({tag, ".fc"}, 32'(frame_cnt), 32'(m_fcnt));
    chk({tag, ".err"}, 32'(ack_err), 32'(m_err));
`ifdef TOF_OVERFLOW_CNT_EN
    for (int i = 0; i < 8; i++) chk({tag, ".ovf"}, 32'(ovf_cnt[i*8 +: 8]), 32'(m_ovf[i]));
`endif
  endtask

  // One clock of the reference behaviour, then compare all outputs.
  task automatic cycle(input string tag);
    bit cons;
    int c;
    logic [7:0] nc, hitm;
    cons = rd_ack && !m_ackq;
    c = int'(ToF_Index);
    m_rd = m_hold[c];
    hitm = '0;
    nc = (m_cons == 8'hFF) ? 8'h00 : m_cons;
    if (m_cons == 8'hFF) m_fcnt = (m_fcnt + 1) % 16;
    if (cons && m_dr[c]) begin hitm[c] = 1'b1; nc[c] = 1'b1; end
    else if (cons) m_err = 1'b1;
`ifdef TOF_OVERFLOW_CNT_EN
    for (int i = 0; i < 8; i++)
      if (sample_valid[i] && m_dr[i] && !hitm[i] && m_ovf[i] < 255) m_ovf[i]++;
`endif
    m_dr = m_dr & ~hitm;
    for (int i = 0; i < 8; i++)
      if (sample_valid[i]) begin m_hold[i] = sample_data[i*16 +: 16]; m_dr[i] = 1'b1; end
    m_cons = nc;
    m_fd = (nc == 8'hFF);
    m_ackq = rd_ack;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic fill(input logic [7:0] mask);
    sample_valid = mask;
    for (int i = 0; i < 8; i++) sample_data[i*16 +: 16] = 16'($urandom);
    cycle("fill");
    sample_valid = '0;
  endtask

  task automatic consume(input int c);
    ToF_Index = 3'(c);
    rd_ack = 1'b1;
    cycle("cons_hi1");
    cycle("cons_hi2");
    rd_ack = 1'b0;
    cycle("cons_lo");
  endtask

  initial begin
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample_valid = 8'h01;
    sample_data[15:0] = 16'h1234;
    cycle("ch0_load");
    sample_valid = '0;
    chk("ch0_dr", 32'(ToF_dr), 32'h01);
    ToF_Index = 3'd0;
    cycle("ch0_sel");
    chk("ch0_rd", 32'(rd_data), 32'h1234);
    fill(8'h08);
    consume(3);
    chk("ch3_once", 32'(ToF_dr), 32'h01);
    chk("ch3_noerr", 32'(ack_err), 32'h0);
    fill(8'hFF);
    for (int c = 7; c >= 0; c--) consume(c);
    chk("frame1", 32'(frame_cnt), 32'h1);
    for (int f = 0; f < 16; f++) begin
      fill(8'hFF);
      for (int c = 7; c >= 0; c--) consume(c);
      cycle("idle");
    end
    chk("wrap", 32'(frame_cnt), 32'h1);
    sample_valid = 8'h20;
    sample_data[80 +: 16] = 16'h1111;
    cycle("ch5_first");
    sample_valid = 8'h20;
    sample_data[80 +: 16] = 16'hBEEF;
    ToF_Index = 3'd5;
    rd_ack = 1'b1;
    cycle("ch5_both");
    chk("ch5_old_rd", 32'(rd_data), 32'h1111);
    sample_valid = '0;
    cycle("ch5_hold");
    rd_ack = 1'b0;
    cycle("ch5_rel");
    chk("ch5_dr", 32'(ToF_dr[5]), 32'h1);
    chk("ch5_rd", 32'(rd_data), 32'hBEEF);
    consume(2);
    chk("ch2_err", 32'(ack_err), 32'h1);
    repeat (3) cycle("err_sticky");
    for (int n = 0; n < 400; n++) begin
      sample_valid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      for (int i = 0; i < 8; i++) sample_data[i*16 +: 16] = 16'($urandom);
      ToF_Index = 3'($urandom);
      rd_ack = ($urandom_range(0, 2) != 0);
      cycle("rand");
    end
    sample_valid = '0;
    rd_ack = 1'b0;
    cycle("rand_end");
`ifdef TOF_OVERFLOW_CNT_EN
    sample_valid = 8'h02;
    repeat (300) begin
      sample_data[31:16] = 16'($urandom);
      cycle("ovf");
    end
    sample_valid = '0;
    chk("ovf_sat", 32'(ovf_cnt[15:8]), 32'hFF);
`endif
    fill(8'hFF);
    chk("all_full", 32'(ToF_dr), 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_dr", 32'(ToF_dr), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle("post_rst");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
